// File: rtl/data_memory_pkg.sv
// Shared widths and types for the byte-addressable 16-bit data memory.
package data_memory_pkg;
  localparam int WORD_W             = 16;
  localparam int BYTE_W             = 8;
  localparam int ADDR_WIDTH_DEFAULT = 8;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [BYTE_W-1:0] byte_t;
endpackage

// File: rtl/data_memory_byte_array.sv
// Byte storage with two read ports and two write ports (high/low byte of a word).
// A synchronous reset clears every byte; it has priority over writes.
module data_memory_byte_array
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr_hi,
  input  logic [ADDR_WIDTH-1:0] addr_lo,
  input  byte_t                 wr_hi,
  input  byte_t                 wr_lo,
  output byte_t                 rd_hi,
  output byte_t                 rd_lo
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  byte_t mem [DEPTH];

  // addr_hi and addr_lo are always distinct, so the two write ports never collide
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[addr_hi] <= wr_hi;
      mem[addr_lo] <= wr_lo;
    end
  end

  assign rd_hi = mem[addr_hi];
  assign rd_lo = mem[addr_lo];
endmodule

// File: rtl/data_memory.sv
// Big-endian 16-bit word memory at any byte address; combinational gated reads.
// Optional macro DATA_MEMORY_RANGE_CHECK_EN rejects accesses above the array or at the top byte.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
  input  logic  Clock,
  input  logic  Reset,
  input  word_t Adresa,
  input  word_t WriteData,
  input  logic  MemWrite,
  input  logic  MemRead,
  output word_t ReadData
);
  logic [ADDR_WIDTH-1:0] addr_hi;
  logic [ADDR_WIDTH-1:0] addr_lo;
  logic                  in_range;
  byte_t                 rd_hi;
  byte_t                 rd_lo;

  assign addr_hi = Adresa[ADDR_WIDTH-1:0];
  // Truncating add gives the wrap from the top byte back to byte 0
  assign addr_lo = addr_hi + ADDR_WIDTH'(1);

`ifdef DATA_MEMORY_RANGE_CHECK_EN
  assign in_range = (Adresa[WORD_W-1:ADDR_WIDTH] == '0) && (addr_hi != '1);
`else
  logic unused_upper;
  assign unused_upper = ^Adresa[WORD_W-1:ADDR_WIDTH];
  assign in_range     = 1'b1;
`endif

  data_memory_byte_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk    (Clock),
    .rst    (Reset),
    .wr_en  (MemWrite && in_range),
    .addr_hi(addr_hi),
    .addr_lo(addr_lo),
    .wr_hi  (WriteData[WORD_W-1:BYTE_W]),
    .wr_lo  (WriteData[BYTE_W-1:0]),
    .rd_hi  (rd_hi),
    .rd_lo  (rd_lo)
  );

  assign ReadData = (MemRead && in_range) ? {rd_hi, rd_lo} : '0;
endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory with hand-computed expected words.
module tb_data_memory;
  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] Adresa;
  logic [15:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [15:0] ReadData;

  int total = 0;
  int bad   = 0;

  data_memory #(.ADDR_WIDTH(8)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Adresa   (Adresa),
    .WriteData(WriteData),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .ReadData (ReadData)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    Adresa  = a;
    MemRead = 1'b1;
    #1;
    chk(tag, ReadData, exp);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    Adresa    = a;
    WriteData = d;
    MemWrite  = 1'b1;
    tick();
    MemWrite  = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Adresa = '0; WriteData = '0; MemWrite = 1'b0; MemRead = 1'b0;
    tick();
    Reset = 1'b0;

    rd("rst_a0", 16'd0, 16'h0000);
    rd("rst_a9", 16'd9, 16'h0000);
    rd("rst_a255", 16'd255, 16'h0000);

    wr(16'd9, 16'h3333);
    rd("wr9_rd9", 16'd9, 16'h3333);
    rd("wr9_rd10", 16'd10, 16'h3300);
    rd("wr9_rd8", 16'd8, 16'h0033);

    Adresa = 16'd9; MemRead = 1'b0; #1;
    chk("gate_off", ReadData, 16'h0000);
    MemRead = 1'b1; #1;
    chk("gate_on", ReadData, 16'h3333);

    wr(16'd4, 16'h1234);
    rd("wr4_rd4", 16'd4, 16'h1234);
    rd("wr4_rd5", 16'd5, 16'h3400);
    rd("wr4_rd3", 16'd3, 16'h0012);

    wr(16'd255, 16'hABCD);
`ifdef DATA_MEMORY_RANGE_CHECK_EN
    rd("top_rd255", 16'd255, 16'h0000);
    rd("top_rd0", 16'd0, 16'h0000);
    rd("alias_rd", 16'h0109, 16'h0000);
`else
    rd("top_rd255", 16'd255, 16'hABCD);
    rd("top_rd0", 16'd0, 16'hCD00);
    rd("top_rd254", 16'd254, 16'h00AB);
    rd("alias_rd", 16'h0109, 16'h3333);
`endif

    // Read and write together: old data before the edge, new data after
    Adresa = 16'd9; MemRead = 1'b1; WriteData = 16'hBEEF; MemWrite = 1'b1; #1;
    chk("rw_pre", ReadData, 16'h3333);
    tick();
    MemWrite = 1'b0; #1;
    chk("rw_post", ReadData, 16'hBEEF);

    wr(16'd11, 16'h7788);
    rd("odd_overlap", 16'd10, 16'hEF77);

    Adresa = 16'd9; WriteData = 16'hFFFF; MemWrite = 1'b0;
    tick();
    rd("no_write", 16'd9, 16'hBEEF);

    // Reset wins over a simultaneous write and clears everything
    Adresa = 16'd20; WriteData = 16'h5555; MemWrite = 1'b1; Reset = 1'b1;
    tick();
    Reset = 1'b0; MemWrite = 1'b0;
    rd("rstwr_rd20", 16'd20, 16'h0000);
    rd("rstwr_rd9", 16'd9, 16'h0000);
    rd("rstwr_rd4", 16'd4, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
